// File: rtl/road_fighter_pkg.sv
// Shared types and constants for the road fighter player logic.
// Holds the motion state encoding, datapath widths and the default road borders.
package road_fighter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE    = 2'd1,
    ST_CRASH   = 2'd2,
    ST_RECOVER = 2'd3
  } motion_state_e;

  localparam int COORD_W       = 11;
  localparam int DIST_W        = 16;
  localparam int DEF_INITIAL_X = 303;
  localparam int DEF_INITIAL_Y = 400;
  localparam int DEF_X_MIN     = 210;
  localparam int DEF_X_MAX     = 360;

endpackage

// File: rtl/speed_ctrl.sv
// Next-frame speed for the player car.
// Braking takes precedence over accelerating; the result is clamped to [0, MAX_SPEED].
module speed_ctrl #(
  parameter int SPEED_W   = 5,
  parameter int MAX_SPEED = 15,
  parameter int ACCEL     = 1
) (
  input  logic [SPEED_W-1:0] speed,
  input  logic               accel_key,
  input  logic               brake_key,
  output logic [SPEED_W-1:0] speed_next
);

  localparam logic [SPEED_W:0] MAX_C = (SPEED_W+1)'(MAX_SPEED);
  localparam logic [SPEED_W:0] INC_C = (SPEED_W+1)'(ACCEL);
  localparam logic [SPEED_W:0] DEC_C = (SPEED_W+1)'(2 * ACCEL);

  logic [SPEED_W:0] wide_s;
  logic [SPEED_W:0] sum_s;

  // Saturating brake/accelerate step, one extra bit so the sum cannot wrap.
  always_comb begin
    wide_s     = {1'b0, speed};
    sum_s      = wide_s + INC_C;
    speed_next = speed;
    if (brake_key) begin
      if (wide_s > DEC_C) begin
        speed_next = SPEED_W'(wide_s - DEC_C);
      end else begin
        speed_next = {SPEED_W{1'b0}};
      end
    end else if (accel_key) begin
      if (sum_s < MAX_C) begin
        speed_next = SPEED_W'(sum_s);
      end else begin
        speed_next = SPEED_W'(MAX_C);
      end
    end else begin
      speed_next = speed;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player car motion: lateral steering within the road, speed, distance,
// crash timeout and post-respawn invulnerability window.
module player_motion_ctrl
  import road_fighter_pkg::*;
#(
  parameter int INITIAL_X      = DEF_INITIAL_X,
  parameter int INITIAL_Y      = DEF_INITIAL_Y,
  parameter int X_MIN          = DEF_X_MIN,
  parameter int X_MAX          = DEF_X_MAX,
  parameter int X_SPEED        = 2,
  parameter int SPEED_W        = 5,
  parameter int MAX_SPEED      = 15,
  parameter int ACCEL          = 1,
  parameter int CRASH_SEC      = 3,
  parameter int RECOVER_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      onesec,
  input  logic                      freeze,
  input  logic                      move_r_key,
  input  logic                      move_l_key,
  input  logic                      accel_key,
  input  logic                      brake_key,
  input  logic                      collision,
  output logic signed [COORD_W-1:0] topLeftX,
  output logic signed [COORD_W-1:0] topLeftY,
  output logic [SPEED_W-1:0]        speed,
  output logic [DIST_W-1:0]         distance,
  output logic                      totalCollision,
  output logic                      invulnerable
);

  localparam int CRASH_W = $clog2(CRASH_SEC + 1);
  localparam int REC_W   = $clog2(RECOVER_FRAMES + 1);

  localparam logic signed [COORD_W-1:0] INIT_X_C = COORD_W'(INITIAL_X);
  localparam logic signed [COORD_W-1:0] INIT_Y_C = COORD_W'(INITIAL_Y);
  localparam logic signed [COORD_W-1:0] X_MIN_C  = COORD_W'(X_MIN);
  localparam logic signed [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
  localparam logic signed [COORD_W-1:0] X_STEP_C = COORD_W'(X_SPEED);
  localparam logic [CRASH_W-1:0]        CRASH_END_C = CRASH_W'(CRASH_SEC);
  localparam logic [CRASH_W-1:0]        CRASH_ONE_C = CRASH_W'(1);
  localparam logic [REC_W-1:0]          REC_END_C   = REC_W'(RECOVER_FRAMES);
  localparam logic [REC_W-1:0]          REC_ONE_C   = REC_W'(1);

  motion_state_e             state_r, state_s;
  logic signed [COORD_W-1:0] x_r, x_s, x_right_s, x_left_s;
  logic [SPEED_W-1:0]        speed_r, speed_s, speed_step_s;
  logic [DIST_W-1:0]         dist_r, dist_s;
  logic [CRASH_W-1:0]        crash_cnt_r, crash_cnt_s;
  logic [REC_W-1:0]          frame_cnt_r, frame_cnt_s;
  logic                      right_req_s, left_req_s, border_s;

  speed_ctrl #(
    .SPEED_W  (SPEED_W),
    .MAX_SPEED(MAX_SPEED),
    .ACCEL    (ACCEL)
  ) u_speed_ctrl (
    .speed     (speed_r),
    .accel_key (accel_key),
    .brake_key (brake_key),
    .speed_next(speed_step_s)
  );

  // Steering request and border check; a stationary car cannot steer.
  always_comb begin
    right_req_s = move_r_key & ~move_l_key & (speed_r != {SPEED_W{1'b0}});
    left_req_s  = move_l_key & ~move_r_key & (speed_r != {SPEED_W{1'b0}});
    x_right_s   = x_r + X_STEP_C;
    x_left_s    = x_r - X_STEP_C;
    border_s    = (right_req_s & (x_right_s > X_MAX_C)) |
                  (left_req_s  & (x_left_s  < X_MIN_C));
  end

  // Next-state and datapath update; a crash always pre-empts the frame update.
  always_comb begin
    state_s     = state_r;
    x_s         = x_r;
    speed_s     = speed_r;
    dist_s      = dist_r;
    crash_cnt_s = crash_cnt_r;
    frame_cnt_s = frame_cnt_r;
    case (state_r)
      ST_IDLE: begin
        x_s     = INIT_X_C;
        speed_s = {SPEED_W{1'b0}};
        if (startOfFrame) begin
          state_s = ST_MOVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MOVE, ST_RECOVER: begin
        if (((state_r == ST_MOVE) && collision) || (startOfFrame && border_s)) begin
          state_s     = ST_CRASH;
          speed_s     = {SPEED_W{1'b0}};
          crash_cnt_s = {CRASH_W{1'b0}};
        end else if (startOfFrame) begin
          dist_s  = dist_r + DIST_W'(speed_r);
          speed_s = speed_step_s;
          if (right_req_s) begin
            x_s = x_right_s;
          end else if (left_req_s) begin
            x_s = x_left_s;
          end else begin
            x_s = x_r;
          end
          if (state_r == ST_RECOVER) begin
            frame_cnt_s = frame_cnt_r + REC_ONE_C;
            if (frame_cnt_s == REC_END_C) begin
              state_s = ST_MOVE;
            end else begin
              state_s = ST_RECOVER;
            end
          end else begin
            state_s = ST_MOVE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_CRASH: begin
        // Exit uses the count before any increment arriving in the same cycle.
        if (startOfFrame && (crash_cnt_r == CRASH_END_C)) begin
          state_s     = ST_RECOVER;
          x_s         = INIT_X_C;
          frame_cnt_s = {REC_W{1'b0}};
        end else if (onesec && (crash_cnt_r != CRASH_END_C)) begin
          crash_cnt_s = crash_cnt_r + CRASH_ONE_C;
        end else begin
          crash_cnt_s = crash_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State registers; freeze holds everything and drops pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ST_IDLE;
      x_r         <= INIT_X_C;
      speed_r     <= {SPEED_W{1'b0}};
      dist_r      <= {DIST_W{1'b0}};
      crash_cnt_r <= {CRASH_W{1'b0}};
      frame_cnt_r <= {REC_W{1'b0}};
    end else if (!freeze) begin
      state_r     <= state_s;
      x_r         <= x_s;
      speed_r     <= speed_s;
      dist_r      <= dist_s;
      crash_cnt_r <= crash_cnt_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign topLeftX       = x_r;
  assign topLeftY       = INIT_Y_C;
  assign speed          = speed_r;
  assign distance       = dist_r;
  assign totalCollision = (state_r == ST_CRASH);
  assign invulnerable   = (state_r == ST_RECOVER);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the car.
module tb_player_motion_ctrl;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0, onesec = 1'b0, freeze = 1'b0;
  logic move_r_key = 1'b0, move_l_key = 1'b0, accel_key = 1'b0, brake_key = 1'b0;
  logic collision = 1'b0;
  logic signed [10:0] topLeftX, topLeftY;
  logic [4:0] speed;
  logic [15:0] distance;
  logic totalCollision, invulnerable;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .onesec(onesec),
    .freeze(freeze), .move_r_key(move_r_key), .move_l_key(move_l_key),
    .accel_key(accel_key), .brake_key(brake_key), .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .speed(speed), .distance(distance),
    .totalCollision(totalCollision), .invulnerable(invulnerable)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model: mode 0 idle, 1 driving, 2 crashed, 3 recovering
  int m_mode, m_x, m_speed, m_dist, m_csec, m_rframes;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 303; m_speed = 0; m_dist = 0; m_csec = 0; m_rframes = 0;
  endtask

  task automatic model_crash();
    m_mode = 2; m_speed = 0; m_csec = 0;
  endtask

  task automatic model_frame();
    int dx;
    dx = 0;
    if (m_speed != 0 && move_r_key != move_l_key) begin
      dx = move_r_key ? 2 : -2;
      if (m_x + dx > 360 || m_x + dx < 210) begin
        model_crash();
        return;
      end
    end
    m_dist = (m_dist + m_speed) % 65536;
    if (brake_key) m_speed = (m_speed >= 2) ? m_speed - 2 : 0;
    else if (accel_key) m_speed = (m_speed + 1 > 15) ? 15 : m_speed + 1;
    m_x = m_x + dx;
    if (m_mode == 3) begin
      m_rframes++;
      if (m_rframes == 60) m_mode = 1;
    end
  endtask

  task automatic model_clock();
    if (!resetN) begin
      model_reset();
      return;
    end
    if (freeze) return;
    case (m_mode)
      0: if (startOfFrame) m_mode = 1;
      1: if (collision) model_crash(); else if (startOfFrame) model_frame();
      2: if (startOfFrame && m_csec == 3) begin
           m_mode = 3; m_x = 303; m_rframes = 0;
         end else if (onesec && m_csec < 3) m_csec++;
      3: if (startOfFrame) model_frame();
      default: model_reset();
    endcase
  endtask

  // One clock: drive inputs, let the model see the same edge as the DUT.
  task automatic tick(input bit sof, input bit os, input bit fz, input bit r,
                      input bit l, input bit a, input bit b, input bit col);
    startOfFrame = sof; onesec = os; freeze = fz; move_r_key = r;
    move_l_key = l; accel_key = a; brake_key = b; collision = col;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic frame(input bit r, input bit l, input bit a, input bit b);
    tick(1'b1, 1'b0, 1'b0, r, l, a, b, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_tick(input bit os, input bit col);
    tick(1'b0, os, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, col);
  endtask

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("x", int'(topLeftX), m_x);
      chk("y", int'(topLeftY), 400);
      chk("speed", int'(speed), m_speed);
      chk("distance", int'(distance), m_dist);
      chk("totalCollision", int'(totalCollision), (m_mode == 2) ? 1 : 0);
      chk("invulnerable", int'(invulnerable), (m_mode == 3) ? 1 : 0);
    end
  end

  initial begin
    int snap_x, snap_d, snap_s;
    model_reset();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", int'(topLeftX), 303);
    chk("rst_y", int'(topLeftY), 400);
    chk("rst_speed", int'(speed), 0);
    chk("rst_dist", int'(distance), 0);
    chk("rst_tc", int'(totalCollision), 0);
    chk("rst_inv", int'(invulnerable), 0);
    resetN = 1'b1;
    chk_en = 1'b1;

    // accelerate from standstill, then steer right
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("accel_speed", int'(speed), 3);
    chk("accel_dist", int'(distance), 3);
    chk("accel_x", int'(topLeftX), 303);
    chk("model_accel_speed", m_speed, 3);
    repeat (5) frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("right_x", int'(topLeftX), 313);
    chk("right_dist", int'(distance), 18);
    chk("model_right_x", m_x, 313);
    frame(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_keys_x", int'(topLeftX), 313);

    // drive into the right border
    repeat (23) frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_border_x", int'(topLeftX), 359);
    snap_d = int'(distance);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("border_tc", int'(totalCollision), 1);
    chk("border_x", int'(topLeftX), 359);
    chk("border_speed", int'(speed), 0);
    chk("border_dist", int'(distance), snap_d);
    idle_tick(1'b1, 1'b0);
    idle_tick(1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("crash_early_tc", int'(totalCollision), 1);
    idle_tick(1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("respawn_inv", int'(invulnerable), 1);
    chk("respawn_x", int'(topLeftX), 303);

    // collisions ignored while invulnerable; window lasts 60 frames
    repeat (4) idle_tick(1'b0, 1'b1);
    chk("inv_ignore_tc", int'(totalCollision), 0);
    repeat (59) frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("inv_59", int'(invulnerable), 1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("inv_60", int'(invulnerable), 0);
    idle_tick(1'b0, 1'b1);
    chk("late_collision_tc", int'(totalCollision), 1);

    // collision coincident with a frame pulse
    repeat (3) idle_tick(1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (60) frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("recovered_speed", int'(speed), 15);
    snap_x = int'(topLeftX);
    snap_d = int'(distance);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("coll_sof_tc", int'(totalCollision), 1);
    chk("coll_sof_x", int'(topLeftX), snap_x);
    chk("coll_sof_dist", int'(distance), snap_d);

    // freeze while driving
    repeat (3) idle_tick(1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (60) frame(1'b0, 1'b0, 1'b1, 1'b0);
    snap_x = int'(topLeftX);
    snap_d = int'(distance);
    snap_s = int'(speed);
    repeat (10) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("freeze_x", int'(topLeftX), snap_x);
    chk("freeze_dist", int'(distance), snap_d);
    chk("freeze_speed", int'(speed), snap_s);
    chk("freeze_tc", int'(totalCollision), 0);

    // reset in the middle of a crash
    idle_tick(1'b0, 1'b1);
    repeat (2) idle_tick(1'b1, 1'b0);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    chk("midrst_tc", int'(totalCollision), 0);
    chk("midrst_x", int'(topLeftX), 303);
    chk("midrst_dist", int'(distance), 0);
    chk("midrst_speed", int'(speed), 0);
    idle_tick(1'b0, 1'b0);
    resetN = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    idle_tick(1'b1, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("counter_cleared_tc", int'(totalCollision), 1);

    // distance wrap at 16 bits
    resetN = 1'b0;
    model_reset();
    idle_tick(1'b0, 1'b0);
    resetN = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5000 && m_dist != 65535; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap_reach_model", m_dist, 65535);
    chk("wrap_pre", int'(distance), 65535);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap_post", int'(distance), 14);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      resetN = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if (!resetN) model_reset();
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
    end
    resetN = 1'b1;
    idle_tick(1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 INITIAL_X, 303, reset/respawn topLeftX
 INITIAL_Y, 400, fixed topLeftY
 X_MIN, 210, leftmost legal topLeftX
 X_MAX, 360, rightmost legal topLeftX
 X_SPEED, 2, lateral step per frame
 SPEED_W, 5, width of speed
 MAX_SPEED, 15, speed ceiling
 ACCEL, 1, speed step per frame
 CRASH_SEC, 3, onesec pulses spent crashed
 RECOVER_FRAMES, 60, invulnerable frames after respawn
REQ-002 Ports (name, direction, width, meaning):
 clk  in  1  clock
 resetN  in  1  async active-low reset
 startOfFrame  in  1  one-cycle frame pulse
 onesec  in  1  one-cycle 1 Hz pulse
 freeze  in  1  pause; holds all state
 move_r_key / move_l_key  in  1  steering
 accel_key / brake_key  in  1  throttle
 collision  in  1  player hit object
 topLeftX / topLeftY  out  11 signed  player position
 speed  out  SPEED_W  vertical speed
 distance  out  16  travelled distance
 totalCollision  out  1  crashed
 invulnerable  out  1  recovery window

Function
REQ-003 FSM states: IDLE, MOVE, CRASH, RECOVER; all outputs are registered or decoded from registered state.
REQ-004 freeze=1: no register changes (state, position, speed, distance, counters); pulses arriving during freeze are lost.
REQ-005 IDLE: X=INITIAL_X, speed=0; on startOfFrame -> MOVE.
REQ-006 MOVE/RECOVER frame update (startOfFrame=1, no crash): distance += old speed, mod 2^16.
REQ-007 Speed: brake_key -> max(speed-2*ACCEL,0); else accel_key -> min(speed+ACCEL,MAX_SPEED); else hold; brake wins over accel.
REQ-008 Steering only when old speed != 0; both keys or none -> X held.
REQ-009 Right: X+X_SPEED <= X_MAX -> X+=X_SPEED; else border crash.
REQ-010 Left: X-X_SPEED >= X_MIN -> X-=X_SPEED; else border crash.
REQ-011 MOVE: collision=1 on any cycle -> CRASH next cycle; beats a simultaneous startOfFrame, which then produces no update.
REQ-012 Border crash -> CRASH; X and distance unchanged that frame.
REQ-013 Entry to CRASH: speed=0, crash counter=0.
REQ-014 CRASH: each onesec increments the crash counter, saturating at CRASH_SEC.
REQ-015 CRASH exit: on the first startOfFrame with counter already == CRASH_SEC (value before any same-cycle increment) -> RECOVER; X=INITIAL_X; frame counter=0.
REQ-016 RECOVER: collision ignored; border crash still -> CRASH.
REQ-017 RECOVER: each startOfFrame increments the frame counter; the frame where it reaches RECOVER_FRAMES -> MOVE.
REQ-018 totalCollision = (state==CRASH); invulnerable = (state==RECOVER); latency one clk after the triggering event.
REQ-019 topLeftY is constant INITIAL_Y; topLeftX sign-extended to 11 bits.

Reset
REQ-020 resetN low, asynchronous: state=IDLE, X=INITIAL_X, Y=INITIAL_Y, speed=0, distance=0, both counters=0, totalCollision=0, invulnerable=0.
REQ-021 Reset mid-CRASH or mid-RECOVER aborts immediately to IDLE values; no partial counts survive.

Structure
REQ-022 Shared package road_fighter_pkg holds the state enum, coordinate width (11), distance width (16) and the default border constants.
REQ-023 Speed saturation logic (REQ-007) lives in sub-module speed_ctrl; all else is in one FSM with separate sequential and combinational processes.
REQ-024 Counter widths are derived with $clog2 of CRASH_SEC+1 and RECOVER_FRAMES+1.

Verification
REQ-025 Reset, then 1 frame, then 3 frames accel_key -> speed=3, distance=3, X=303.
REQ-026 Continue with 5 frames move_r_key at speed 3 -> X=313, distance=18; both keys -> X held.
REQ-027 Steering against the border:
 X=359 plus move_r_key frame -> totalCollision=1 next clk, X=359, speed=0.
 After 3 onesec pulses and the next frame -> invulnerable=1, X=303.
REQ-028 collision coincident with startOfFrame in MOVE -> no speed/X/distance change; CRASH entered.
REQ-029 Recovery window:
 In RECOVER, collision pulses are ignored.
 After 60 frames -> invulnerable=0, state MOVE.
 A later collision -> totalCollision=1.
REQ-030 Reset and freeze:
 freeze held over 10 frames -> all outputs constant.
 resetN pulsed mid-CRASH -> IDLE values at once.
 distance wraps 65535 -> 65535+speed-65536.
